// File: rtl/bus_port_fifo_if.sv
// bus_port_fifo_if
//   Handshake and shared-bus bundle for one bus_port_fifo endpoint.
//   Ports (per modport):
//     send_valid/send_data/send_ready   local sender -> endpoint (ready/valid)
//     recv_valid/recv_data/recv_ready   endpoint receive FIFO -> local consumer
//     bus_data_in/bus_valid_in          resolved shared bus as seen by endpoint
//     bus_data_out/bus_valid_out/bus_oe endpoint drive toward the bus resolver
//   slave  : view used by the endpoint itself
//   master : view used by the surrounding fabric / local logic
//   Optional macro BUS_PARITY_EN adds bus_par_in / bus_par_out.
interface bus_port_fifo_if #(
    parameter int DATA_W = 8
);
    logic              send_valid;
    logic [DATA_W-1:0] send_data;
    logic              send_ready;
    logic              recv_valid;
    logic [DATA_W-1:0] recv_data;
    logic              recv_ready;
    logic [DATA_W-1:0] bus_data_in;
    logic              bus_valid_in;
    logic [DATA_W-1:0] bus_data_out;
    logic              bus_valid_out;
    logic              bus_oe;
`ifdef BUS_PARITY_EN
    logic              bus_par_in;
    logic              bus_par_out;

    modport slave (
        input  send_valid, send_data, recv_ready, bus_data_in, bus_valid_in, bus_par_in,
        output send_ready, recv_valid, recv_data, bus_data_out, bus_valid_out, bus_oe, bus_par_out
    );

    modport master (
        output send_valid, send_data, recv_ready, bus_data_in, bus_valid_in, bus_par_in,
        input  send_ready, recv_valid, recv_data, bus_data_out, bus_valid_out, bus_oe, bus_par_out
    );
`else
    modport slave (
        input  send_valid, send_data, recv_ready, bus_data_in, bus_valid_in,
        output send_ready, recv_valid, recv_data, bus_data_out, bus_valid_out, bus_oe
    );

    modport master (
        output send_valid, send_data, recv_ready, bus_data_in, bus_valid_in,
        input  send_ready, recv_valid, recv_data, bus_data_out, bus_valid_out, bus_oe
    );
`endif
endinterface

// File: rtl/bus_port_fifo.sv
// bus_port_fifo
//   Shared-bus endpoint for the crypto interconnect. Decodes header beats,
//   takes bus ownership after a programmable grant delay when it is the
//   named source, and buffers received payload in a ready/valid FIFO.
//   Ports:
//     clk, rst_n      clock (rising edge) and synchronous active-low reset
//     source_id       this endpoint's static ID
//     ack             broadcast end-of-transaction
//     bus             bus_port_fifo_if.slave: send/recv handshakes, bus in/out/oe
//     rx_overflow     sticky, a beat was dropped because the FIFO was full
//     hdr_src/dest    latched header fields
//     busy            not idle
//   Optional macro BUS_PARITY_EN: even parity on the bus (bus_par_in/out in the
//   interface) and a sticky parity_err output.
module bus_port_fifo #(
    parameter int              DATA_W      = 8,
    parameter int              ID_W        = 2,
    parameter logic [ID_W-1:0] CTRL_ID     = {ID_W{1'b1}},
    parameter int              GRANT_DELAY = 3,
    parameter int              RX_DEPTH    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ID_W-1:0]   source_id,
    input  logic              ack,
    bus_port_fifo_if.slave    bus,
    output logic              rx_overflow,
    output logic [ID_W-1:0]   hdr_src,
    output logic [ID_W-1:0]   hdr_dest,
    output logic              busy
`ifdef BUS_PARITY_EN
    ,
    output logic              parity_err
`endif
);

    localparam int PTR_W = $clog2(RX_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        CTRL_TX,
        WAIT_GRANT,
        OWN_TX,
        LISTEN,
        IGNORE
    } state_t;

    state_t            state;
    logic [3:0]        grant_cnt;

    logic [DATA_W-1:0] mem [RX_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;

    logic [ID_W-1:0]   rx_src;
    logic [ID_W-1:0]   rx_dest;
    logic [ID_W-1:0]   tx_src;
    logic [ID_W-1:0]   tx_dest;
    logic              is_ctrl;
    logic              par_bad;
    logic              rx_beat;
    logic              push;
    logic              pop;
    logic              full;
    logic              do_push;

    assign rx_src  = bus.bus_data_in[ID_W+1:2];
    assign rx_dest = bus.bus_data_in[2*ID_W+1:ID_W+2];
    assign tx_src  = bus.send_data[ID_W+1:2];
    assign tx_dest = bus.send_data[2*ID_W+1:ID_W+2];
    assign is_ctrl = (source_id == CTRL_ID);

    // Bus drive is a pure decode of the state register, so leaving a driving
    // state (ack or reset) releases the bus on that same clock edge.
    assign bus.bus_oe        = (state == CTRL_TX) || (state == OWN_TX);
    assign bus.bus_valid_out = bus.bus_oe && bus.send_valid;
    assign bus.bus_data_out  = bus.bus_oe ? bus.send_data : '0;
    assign bus.send_ready    = bus.bus_oe;
    assign busy              = (state != IDLE);

`ifdef BUS_PARITY_EN
    assign par_bad         = bus.bus_par_in != (^bus.bus_data_in);
    assign bus.bus_par_out = bus.bus_oe && (^bus.bus_data_out);
`else
    assign par_bad = 1'b0;
`endif

    // A corrupt beat is treated as if it never appeared on the bus.
    assign rx_beat = bus.bus_valid_in && !par_bad;

    // Only payload is buffered; headers are consumed in IDLE and our own
    // driven beats (CTRL_TX / OWN_TX) are never looped back.
    assign push    = rx_beat && ((state == LISTEN) || (state == WAIT_GRANT));
    assign pop     = bus.recv_valid && bus.recv_ready;
    assign full    = (count == (PTR_W+1)'(RX_DEPTH));
    assign do_push = push && (!full || pop);

    assign bus.recv_valid = (count != '0);
    assign bus.recv_data  = mem[rd_ptr];

    // Transaction FSM. The grant counter is loaded with GRANT_DELAY on the
    // header and OWN_TX is entered as it steps down to 1, so the source
    // drives exactly GRANT_DELAY cycles after the header cycle. With a delay
    // of 1 there is no room for WAIT_GRANT and the header goes straight to
    // OWN_TX. ack is applied last so it overrides every other transition.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            grant_cnt <= '0;
            hdr_src   <= '0;
            hdr_dest  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (is_ctrl && bus.send_valid) begin
                        state <= CTRL_TX;
                    end else if (rx_beat) begin
                        hdr_src  <= rx_src;
                        hdr_dest <= rx_dest;
                        if (source_id == rx_src) begin
                            if (GRANT_DELAY <= 1) begin
                                state <= OWN_TX;
                            end else begin
                                state     <= WAIT_GRANT;
                                grant_cnt <= 4'(GRANT_DELAY);
                            end
                        end else if ((source_id == rx_dest) || is_ctrl) begin
                            state <= LISTEN;
                        end else begin
                            state <= IGNORE;
                        end
                    end
                end
                CTRL_TX: begin
                    if (bus.send_valid) begin
                        hdr_src  <= tx_src;
                        hdr_dest <= tx_dest;
                        state    <= LISTEN;
                    end
                end
                WAIT_GRANT: begin
                    grant_cnt <= grant_cnt - 4'd1;
                    if (grant_cnt <= 4'd2) begin
                        state <= OWN_TX;
                    end
                end
                default: begin
                end
            endcase
            if (ack && (state != IDLE)) begin
                state     <= IDLE;
                grant_cnt <= '0;
            end
        end
    end

    // FIFO storage carries no reset; flushing is done by clearing the pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= bus.bus_data_in;
        end
    end

    // FIFO pointers and occupancy. A push into a full FIFO only succeeds when
    // a pop frees the head slot in the same cycle; otherwise it is dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            rx_overflow <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && full && !pop) begin
                rx_overflow <= 1'b1;
            end
            case ({do_push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef BUS_PARITY_EN
    // Flag corrupt beats only where the port would have consumed them:
    // headers in IDLE and payload while collecting.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            parity_err <= 1'b0;
        end else if (bus.bus_valid_in && par_bad &&
                     (((state == IDLE) && !(is_ctrl && bus.send_valid)) ||
                      (state == LISTEN) || (state == WAIT_GRANT))) begin
            parity_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_bus_port_fifo.sv
// tb_bus_port_fifo
//   Directed self-checking bench for bus_port_fifo with default parameters
//   (DATA_W=8, ID_W=2, CTRL_ID=3, GRANT_DELAY=3, RX_DEPTH=4). Inputs are
//   driven 1 time unit after the rising edge and outputs are sampled there.
module tb_bus_port_fifo;

    logic       clk;
    logic       rst_n;
    logic [1:0] source_id;
    logic       ack;
    logic       rx_overflow;
    logic [1:0] hdr_src;
    logic [1:0] hdr_dest;
    logic       busy;
`ifdef BUS_PARITY_EN
    logic       parity_err;
`endif

    int checks = 0;
    int errors = 0;

    bus_port_fifo_if #(.DATA_W(8)) bus_if ();

`ifdef BUS_PARITY_EN
    assign bus_if.bus_par_in = ^bus_if.bus_data_in;
`endif

    bus_port_fifo dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .source_id   (source_id),
        .ack         (ack),
        .bus         (bus_if),
        .rx_overflow (rx_overflow),
        .hdr_src     (hdr_src),
        .hdr_dest    (hdr_dest),
        .busy        (busy)
`ifdef BUS_PARITY_EN
        ,
        .parity_err  (parity_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [1:0] id);
        source_id            = id;
        ack                  = 1'b0;
        bus_if.send_valid    = 1'b0;
        bus_if.send_data     = 8'h00;
        bus_if.recv_ready    = 1'b0;
        bus_if.bus_valid_in  = 1'b0;
        bus_if.bus_data_in   = 8'h00;
        rst_n                = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset;
        source_id           = 2'd2;
        ack                 = 1'b0;
        bus_if.recv_ready   = 1'b0;
        bus_if.send_valid   = 1'b1;
        bus_if.send_data    = 8'hA5;
        bus_if.bus_valid_in = 1'b1;
        bus_if.bus_data_in  = 8'h28;
        rst_n               = 1'b0;
        tick();
        tick();
        checks++; if (bus_if.send_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_send_ready: got %b expected 0", bus_if.send_ready); end
        checks++; if (bus_if.bus_oe !== 1'b0) begin errors++; $display("[TB] FAIL rst_bus_oe: got %b expected 0", bus_if.bus_oe); end
        checks++; if (bus_if.bus_valid_out !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid_out: got %b expected 0", bus_if.bus_valid_out); end
        checks++; if (bus_if.bus_data_out !== 8'h00) begin errors++; $display("[TB] FAIL rst_data_out: got %h expected 00", bus_if.bus_data_out); end
        checks++; if (bus_if.recv_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_recv_valid: got %b expected 0", bus_if.recv_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy: got %b expected 0", busy); end
        checks++; if (rx_overflow !== 1'b0) begin errors++; $display("[TB] FAIL rst_overflow: got %b expected 0", rx_overflow); end
        checks++; if ({hdr_src, hdr_dest} !== 4'h0) begin errors++; $display("[TB] FAIL rst_hdr: got %h expected 0", {hdr_src, hdr_dest}); end
        bus_if.bus_valid_in = 1'b0;
        bus_if.send_valid   = 1'b0;
        rst_n               = 1'b1;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_release_busy: got %b expected 0", busy); end
    endtask

    task automatic test_grant;
        do_reset(2'd2);
        bus_if.bus_valid_in = 1'b1;
        bus_if.bus_data_in  = 8'h28;
        tick();
        bus_if.bus_valid_in = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL grant_busy: got %b expected 1", busy); end
        checks++; if (hdr_src !== 2'd2 || hdr_dest !== 2'd2) begin errors++; $display("[TB] FAIL grant_hdr: got %0d/%0d expected 2/2", hdr_src, hdr_dest); end
        checks++; if (bus_if.bus_oe !== 1'b0) begin errors++; $display("[TB] FAIL grant_oe_t1: got %b expected 0", bus_if.bus_oe); end
        tick();
        checks++; if (bus_if.bus_oe !== 1'b0) begin errors++; $display("[TB] FAIL grant_oe_t2: got %b expected 0", bus_if.bus_oe); end
        tick();
        checks++; if (bus_if.bus_oe !== 1'b1) begin errors++; $display("[TB] FAIL grant_oe_t3: got %b expected 1", bus_if.bus_oe); end
        checks++; if (bus_if.send_ready !== 1'b1) begin errors++; $display("[TB] FAIL grant_ready_t3: got %b expected 1", bus_if.send_ready); end
        bus_if.send_valid = 1'b1;
        bus_if.send_data  = 8'hA5;
        #1;
        checks++; if (bus_if.bus_data_out !== 8'hA5) begin errors++; $display("[TB] FAIL grant_data_out: got %h expected a5", bus_if.bus_data_out); end
        checks++; if (bus_if.bus_valid_out !== 1'b1) begin errors++; $display("[TB] FAIL grant_valid_out: got %b expected 1", bus_if.bus_valid_out); end
        rst_n = 1'b0;
        tick();
        checks++; if (bus_if.bus_oe !== 1'b0 || bus_if.bus_valid_out !== 1'b0) begin errors++; $display("[TB] FAIL grant_reset_release: got oe=%b valid=%b expected 0/0", bus_if.bus_oe, bus_if.bus_valid_out); end
        rst_n             = 1'b1;
        bus_if.send_valid = 1'b0;
        tick();
    endtask

    task automatic test_wait_payload;
        do_reset(2'd1);
        bus_if.bus_valid_in = 1'b1;
        bus_if.bus_data_in  = 8'h14;
        tick();
        bus_if.bus_data_in = 8'h5A;
        checks++; if (busy !== 1'b1 || bus_if.bus_oe !== 1'b0) begin errors++; $display("[TB] FAIL wait_state: got busy=%b oe=%b expected 1/0", busy, bus_if.bus_oe); end
        tick();
        bus_if.bus_valid_in = 1'b0;
        checks++; if (bus_if.recv_valid !== 1'b1 || bus_if.recv_data !== 8'h5A) begin errors++; $display("[TB] FAIL wait_push: got v=%b d=%h expected 1/5a", bus_if.recv_valid, bus_if.recv_data); end
        tick();
        checks++; if (bus_if.bus_oe !== 1'b1) begin errors++; $display("[TB] FAIL wait_own_oe: got %b expected 1", bus_if.bus_oe); end
        bus_if.bus_valid_in = 1'b1;
        bus_if.bus_data_in  = 8'h77;
        bus_if.send_valid   = 1'b1;
        bus_if.send_data    = 8'h77;
        tick();
        bus_if.bus_valid_in = 1'b0;
        bus_if.send_valid   = 1'b0;
        bus_if.recv_ready   = 1'b1;
        checks++; if (bus_if.recv_data !== 8'h5A) begin errors++; $display("[TB] FAIL wait_head: got %h expected 5a", bus_if.recv_data); end
        tick();
        bus_if.recv_ready = 1'b0;
        checks++; if (bus_if.recv_valid !== 1'b0) begin errors++; $display("[TB] FAIL own_no_loopback: got %b expected 0", bus_if.recv_valid); end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        checks++; if (busy !== 1'b0 || bus_if.bus_oe !== 1'b0) begin errors++; $display("[TB] FAIL own_ack: got busy=%b oe=%b expected 0/0", busy, bus_if.bus_oe); end
    endtask

    task automatic test_listen;
        logic [7:0] exp_q [3];
        exp_q = '{8'h11, 8'h22, 8'h33};
        do_reset(2'd1);
        bus_if.bus_valid_in = 1'b1;
        bus_if.bus_data_in  = 8'h18;
        tick();
        checks++; if (busy !== 1'b1 || hdr_src !== 2'd2 || hdr_dest !== 2'd1) begin errors++; $display("[TB] FAIL listen_hdr: got busy=%b src=%0d dest=%0d expected 1/2/1", busy, hdr_src, hdr_dest); end
        bus_if.bus_data_in = 8'h11;
        checks++; if (bus_if.recv_valid !== 1'b0) begin errors++; $display("[TB] FAIL listen_hdr_not_pushed: got %b expected 0", bus_if.recv_valid); end
        tick();
        checks++; if (bus_if.recv_valid !== 1'b1 || bus_if.recv_data !== 8'h11) begin errors++; $display("[TB] FAIL listen_latency: got v=%b d=%h expected 1/11", bus_if.recv_valid, bus_if.recv_data); end
        bus_if.bus_data_in = 8'h22;
        tick();
        bus_if.bus_data_in = 8'h33;
        tick();
        bus_if.bus_valid_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (bus_if.recv_valid !== 1'b1 || bus_if.recv_data !== exp_q[i]) begin errors++; $display("[TB] FAIL listen_pop%0d: got v=%b d=%h expected 1/%h", i, bus_if.recv_valid, bus_if.recv_data, exp_q[i]); end
            bus_if.recv_ready = 1'b1;
            tick();
        end
        bus_if.recv_ready = 1'b0;
        checks++; if (bus_if.recv_valid !== 1'b0) begin errors++; $display("[TB] FAIL listen_empty: got %b expected 0", bus_if.recv_valid); end
    endtask

    task automatic test_overflow;
        logic [7:0] exp_q [4];
        exp_q = '{8'h02, 8'h03, 8'h04, 8'h05};
        bus_if.bus_valid_in = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            bus_if.bus_data_in = 8'(i);
            tick();
        end
        checks++; if (rx_overflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf_fill: got %b expected 0", rx_overflow); end
        bus_if.bus_data_in = 8'h05;
        bus_if.recv_ready  = 1'b1;
        tick();
        bus_if.recv_ready = 1'b0;
        checks++; if (rx_overflow !== 1'b0 || bus_if.recv_data !== 8'h02) begin errors++; $display("[TB] FAIL ovf_push_pop: got ovf=%b head=%h expected 0/02", rx_overflow, bus_if.recv_data); end
        bus_if.bus_data_in = 8'h06;
        tick();
        bus_if.bus_valid_in = 1'b0;
        checks++; if (rx_overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_drop: got %b expected 1", rx_overflow); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus_if.recv_valid !== 1'b1 || bus_if.recv_data !== exp_q[i]) begin errors++; $display("[TB] FAIL ovf_pop%0d: got v=%b d=%h expected 1/%h", i, bus_if.recv_valid, bus_if.recv_data, exp_q[i]); end
            bus_if.recv_ready = 1'b1;
            tick();
        end
        bus_if.recv_ready = 1'b0;
        checks++; if (bus_if.recv_valid !== 1'b0 || rx_overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_after: got v=%b ovf=%b expected 0/1", bus_if.recv_valid, rx_overflow); end
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic test_ctrl_ack;
        do_reset(2'd3);
        bus_if.send_valid = 1'b1;
        bus_if.send_data  = 8'h24;
        #1;
        checks++; if (bus_if.send_ready !== 1'b0) begin errors++; $display("[TB] FAIL ctrl_idle_ready: got %b expected 0", bus_if.send_ready); end
        tick();
        bus_if.bus_valid_in = 1'b1;
        bus_if.bus_data_in  = 8'h24;
        checks++; if (bus_if.send_ready !== 1'b1 || bus_if.bus_valid_out !== 1'b1 || bus_if.bus_data_out !== 8'h24) begin errors++; $display("[TB] FAIL ctrl_drive: got rdy=%b v=%b d=%h expected 1/1/24", bus_if.send_ready, bus_if.bus_valid_out, bus_if.bus_data_out); end
        tick();
        bus_if.send_valid   = 1'b0;
        bus_if.bus_valid_in = 1'b0;
        checks++; if (bus_if.send_ready !== 1'b0 || bus_if.bus_oe !== 1'b0) begin errors++; $display("[TB] FAIL ctrl_one_beat: got rdy=%b oe=%b expected 0/0", bus_if.send_ready, bus_if.bus_oe); end
        checks++; if (hdr_src !== 2'd1 || hdr_dest !== 2'd2) begin errors++; $display("[TB] FAIL ctrl_hdr: got %0d/%0d expected 1/2", hdr_src, hdr_dest); end
        checks++; if (busy !== 1'b1 || bus_if.recv_valid !== 1'b0) begin errors++; $display("[TB] FAIL ctrl_listen: got busy=%b v=%b expected 1/0", busy, bus_if.recv_valid); end
        ack                 = 1'b1;
        bus_if.bus_valid_in = 1'b1;
        bus_if.bus_data_in  = 8'h99;
        tick();
        ack                 = 1'b0;
        bus_if.bus_valid_in = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL ctrl_ack_busy: got %b expected 0", busy); end
        checks++; if (bus_if.recv_valid !== 1'b1 || bus_if.recv_data !== 8'h99) begin errors++; $display("[TB] FAIL ctrl_ack_beat: got v=%b d=%h expected 1/99", bus_if.recv_valid, bus_if.recv_data); end
        tick();
        checks++; if (bus_if.recv_valid !== 1'b1) begin errors++; $display("[TB] FAIL ctrl_fifo_survives: got %b expected 1", bus_if.recv_valid); end
        rst_n = 1'b0;
        tick();
        checks++; if (bus_if.recv_valid !== 1'b0) begin errors++; $display("[TB] FAIL ctrl_reset_flush: got %b expected 0", bus_if.recv_valid); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_ignore;
        do_reset(2'd0);
        bus_if.bus_valid_in = 1'b1;
        bus_if.bus_data_in  = 8'h24;
        tick();
        checks++; if (busy !== 1'b1 || hdr_src !== 2'd1 || hdr_dest !== 2'd2) begin errors++; $display("[TB] FAIL ign_hdr: got busy=%b src=%0d dest=%0d expected 1/1/2", busy, hdr_src, hdr_dest); end
        bus_if.bus_data_in = 8'h55;
        tick();
        bus_if.bus_data_in = 8'h66;
        tick();
        bus_if.bus_valid_in = 1'b0;
        checks++; if (bus_if.recv_valid !== 1'b0 || bus_if.bus_oe !== 1'b0) begin errors++; $display("[TB] FAIL ign_discard: got v=%b oe=%b expected 0/0", bus_if.recv_valid, bus_if.bus_oe); end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        checks++; if (busy !== 1'b0 || bus_if.recv_valid !== 1'b0) begin errors++; $display("[TB] FAIL ign_ack: got busy=%b v=%b expected 0/0", busy, bus_if.recv_valid); end
    endtask

    initial begin
        rst_n               = 1'b0;
        source_id           = 2'd0;
        ack                 = 1'b0;
        bus_if.send_valid   = 1'b0;
        bus_if.send_data    = 8'h00;
        bus_if.recv_ready   = 1'b0;
        bus_if.bus_valid_in = 1'b0;
        bus_if.bus_data_in  = 8'h00;
        tick();
        test_reset();
        test_grant();
        test_wait_payload();
        test_listen();
        test_overflow();
        test_ctrl_ack();
        test_ignore();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_port_fifo.md
Name: bus_port_fifo

Overview:
Parametrised next-generation shared-bus endpoint for the crypto interconnect. Generalises the 8-bit/2-bit-ID tri-state port to DATA_W/ID_W, splits the bus into explicit in/out/enable signals, and adds a receive FIFO with ready/valid back-pressure. Ownership passes to the source named in the header after a programmable grant delay. One instance sits per accelerator, plus one for the control node.

Parameters:
DATA_W, 8, bus and payload width; must be >= 2*ID_W+2
ID_W, 2, module ID width
CTRL_ID, {ID_W{1'b1}}, ID of the control node that issues headers
GRANT_DELAY, 3, cycles after the header beat before the source may drive (1..15)
RX_DEPTH, 4, receive FIFO depth; power of two, >= 2

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  synchronous active-low reset
source_id  in  ID_W  this endpoint's ID (static)
send_valid  in  1  local sender has a beat
send_data  in  DATA_W  beat to send
send_ready  out  1  beat accepted this cycle when send_valid && send_ready
ack  in  1  broadcast end-of-transaction
recv_valid  out  1  FIFO non-empty
recv_data  out  DATA_W  FIFO head
recv_ready  in  1  pop FIFO head when recv_valid && recv_ready
rx_overflow  out  1  sticky: a beat was dropped because the FIFO was full
hdr_src  out  ID_W  latched header source
hdr_dest  out  ID_W  latched header destination
busy  out  1  state != IDLE
bus_data_in  in  DATA_W  resolved bus data
bus_valid_in  in  1  resolved bus valid
bus_data_out  out  DATA_W  data to drive
bus_valid_out  out  1  valid to drive
bus_oe  out  1  drive enable; top level resolves the bus

Behaviour:
- Reset (rst_n low at posedge): state IDLE, FIFO empty, grant counter 0, hdr_src/hdr_dest 0, rx_overflow 0. All outputs 0: send_ready, bus_oe, bus_valid_out, recv_valid, busy, and bus_data_out.
- Header beat format: bits[1:0] opcode (passed through, not interpreted), [ID_W+1:2] src, [2*ID_W+1:ID_W+2] dest.
- Bus drive is combinational from state: bus_oe = (state==CTRL_TX || state==OWN_TX); bus_valid_out = bus_oe && send_valid; bus_data_out = send_data when bus_oe, else 0.
- send_ready = bus_oe.
- States:
  - IDLE:
    - If source_id==CTRL_ID and send_valid, go to CTRL_TX.
    - Otherwise, on bus_valid_in, latch hdr_src/hdr_dest from bus_data_in. Then: if source_id==src, go to WAIT_GRANT with counter=GRANT_DELAY; else if source_id==dest or source_id==CTRL_ID, go to LISTEN; else go to IGNORE.
  - CTRL_TX:
    - Exactly one beat. On the accepted beat, latch hdr_src/hdr_dest from send_data and go to LISTEN.
  - WAIT_GRANT:
    - Counter decrements every cycle. When it reaches 1, go to OWN_TX (the source drives GRANT_DELAY cycles after the header cycle).
    - Payload seen on the bus in this state is pushed to the FIFO.
  - OWN_TX:
    - Drives the bus while send_valid; the beat is not looped back into its own FIFO.
  - LISTEN:
    - Every bus_valid_in beat is pushed to the FIFO.
  - IGNORE:
    - Discards all bus traffic.
- ack in any non-IDLE state: next state IDLE, counter 0. A beat coinciding with ack is still delivered (pushed or driven) that cycle. ack in IDLE has no effect. ack has priority over every other transition.
- Header beats are never pushed to the FIFO.
- FIFO:
  - Push when full and no pop: beat dropped, rx_overflow set. rx_overflow clears only on reset.
  - Simultaneous push and pop when full: both succeed, occupancy unchanged.
  - Push to empty: recv_valid next cycle (1-cycle latency).
  - Pointers wrap modulo RX_DEPTH; FIFO contents survive ack.
- Reset mid-transaction: the bus is released on the same clock edge, and the FIFO is flushed.

Optional Feature:
BUS_PARITY_EN:
- When defined, adds two ports: bus_par_out (out 1) = even parity of bus_data_out, qualified by bus_oe, and bus_par_in (in 1).
- Adds a sticky parity_err output (out 1), cleared only by reset.
- A received beat (header or payload) with a parity mismatch is discarded and sets parity_err. A corrupt header leaves the port in IDLE.
- When undefined, none of these ports exist and no checking is done.

Test Plan:
1. Reset: hold rst_n=0 for 2 cycles with bus_valid_in=1 -> all outputs 0, state IDLE; release -> busy=0.
2. Header and grant, source_id=2, GRANT_DELAY=3:
   - Bus header 0x28 (src=2, dest=2), opcode 0 at cycle t -> bus_oe=1 and send_ready=1 at t+3.
   - Send 0xA5 -> bus_data_out=0xA5, bus_valid_out=1.
3. Destination receive, source_id=1:
   - Header 0x14 (src=1, dest=1), opcode 0 -> WAIT_GRANT.
   - Next, header 0x18 (src=2, dest=1) on a fresh port -> LISTEN.
   - Beats 0x11, 0x22, 0x33 -> popped in order; recv_valid one cycle after each push.
4. Overflow, RX_DEPTH=4, recv_ready=0, LISTEN: 5 beats 0x01..0x05 -> FIFO holds 0x01..0x04, rx_overflow=1. Full with simultaneous push and pop -> no overflow.
5. Control and ack, source_id=3: send_valid with 0x24 -> one beat driven, send_ready=1 for 1 cycle, hdr_src=1, hdr_dest=2. ack during LISTEN together with a bus beat -> beat pushed, busy=0 next cycle.
6. Non-participant, source_id=0 and header 0x24 -> IGNORE: payload beats not pushed, recv_valid stays 0 until ack returns the port to IDLE.
